// File: rtl/deserializer.sv
// deserializer: MSB-first serial-to-parallel converter; a word closes on its
// DATA_W-th bit or on a last-bit marker, and is emitted with a valid-bit count.
module deserializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    input  logic              ser_data_last_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o
);
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] word;
    logic [MOD_W-1:0]  cnt;
    logic              full;
    logic              close;

    always_comb begin
        full  = cnt == MOD_W'(DATA_W - 1);
        close = ser_data_val_i && (full || ser_data_last_i);
        // shreg already holds zeros below the current position
        word  = shreg | (DATA_W'(ser_data_i) << (MOD_W'(DATA_W - 1) - cnt));
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            shreg            <= '0;
            cnt              <= '0;
            deser_data_o     <= '0;
            deser_data_mod_o <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= close;
            if (close) begin
                deser_data_o     <= word;
                deser_data_mod_o <= full ? '0 : cnt + 1'b1;
                shreg            <= '0;
                cnt              <= '0;
            end else if (ser_data_val_i) begin
                shreg <= word;
                cnt   <= cnt + 1'b1;
            end
        end
    end
endmodule
